// File: rtl/cmplx_mixer.sv
// Pipelined complex mixer: (re + j*im) * (cos +/- j*sin), scaled by 2^-(pDDS_W-2+pMUL_W).
// Stages: input reg, multiply reg, add/sub reg, optional round reg; one sample per enabled cycle.
module cmplx_mixer #(
  parameter int pIDAT_W      = 16,
  parameter int pDDS_W       = 17,
  parameter int pODAT_W      = 18,
  parameter int pMUL_W       = 0,
  parameter int pCONJ        = 0,
  parameter int pUSE_DSP_ADD = 1,
  parameter int pUSE_ROUND   = 1
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  input  logic                      ival,
  input  logic signed [pIDAT_W-1:0] idat_re,
  input  logic signed [pIDAT_W-1:0] idat_im,
  input  logic signed [pDDS_W-1:0]  icos,
  input  logic signed [pDDS_W-1:0]  isin,
  output logic                      oval,
  output logic signed [pODAT_W-1:0] odat_re,
  output logic signed [pODAT_W-1:0] odat_im
);

  localparam int unsigned PROD_W = pIDAT_W + pDDS_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned SHIFT  = pDDS_W - 2 + pMUL_W;
  localparam int unsigned LAT    = 3 + ((pUSE_ROUND != 0) ? 1 : 0);
  localparam bit          CONJ   = (pCONJ != 0);

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [pIDAT_W-1:0] a,
                                                   input logic signed [pDDS_W-1:0]  b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  function automatic logic signed [SUM_W-1:0] add_sub(input logic signed [PROD_W-1:0] a,
                                                      input logic signed [PROD_W-1:0] b,
                                                      input logic                     sub);
    return sub ? (SUM_W'(a) - SUM_W'(b)) : (SUM_W'(a) + SUM_W'(b));
  endfunction

  logic [LAT-1:0]             val_pipe;
  logic signed [pIDAT_W-1:0]  re1, im1;
  logic signed [pDDS_W-1:0]   cos1, sin1;
  logic signed [SUM_W-1:0]    sum3_re_c, sum3_im_c;
  logic signed [SUM_W-1:0]    sum3_re, sum3_im;

  // valid delay line matches the data latency exactly
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      val_pipe <= '0;
    end else if (iclkena) begin
      val_pipe <= {val_pipe[LAT-2:0], ival};
    end
  end

  assign oval = val_pipe[LAT-1];

  // stage 1: input register
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      re1  <= '0;
      im1  <= '0;
      cos1 <= '0;
      sin1 <= '0;
    end else if (iclkena) begin
      re1  <= idat_re;
      im1  <= idat_im;
      cos1 <= icos;
      sin1 <= isin;
    end
  end

  // stages 2/3: either a post-adder fused with the second multiply, or plain adders
  if (pUSE_DSP_ADD != 0) begin : g_dsp_add
    logic signed [PROD_W-1:0]  p_rc2, p_ic2;
    logic signed [pIDAT_W-1:0] re2, im2;
    logic signed [pDDS_W-1:0]  sin2;
    logic signed [PROD_W-1:0]  p_is_c, p_rs_c;

    always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
        p_rc2 <= '0;
        p_ic2 <= '0;
        re2   <= '0;
        im2   <= '0;
        sin2  <= '0;
      end else if (iclkena) begin
        p_rc2 <= mul(re1, cos1);
        p_ic2 <= mul(im1, cos1);
        re2   <= re1;
        im2   <= im1;
        sin2  <= sin1;
      end
    end

    always_comb begin
      p_is_c    = mul(im2, sin2);
      p_rs_c    = mul(re2, sin2);
      sum3_re_c = add_sub(p_rc2, p_is_c, !CONJ);
      sum3_im_c = add_sub(p_ic2, p_rs_c, CONJ);
    end
  end else begin : g_sep_add
    logic signed [PROD_W-1:0] p_rc2, p_is2, p_rs2, p_ic2;

    always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
        p_rc2 <= '0;
        p_is2 <= '0;
        p_rs2 <= '0;
        p_ic2 <= '0;
      end else if (iclkena) begin
        p_rc2 <= mul(re1, cos1);
        p_is2 <= mul(im1, sin1);
        p_rs2 <= mul(re1, sin1);
        p_ic2 <= mul(im1, cos1);
      end
    end

    always_comb begin
      sum3_re_c = add_sub(p_rc2, p_is2, !CONJ);
      sum3_im_c = add_sub(p_ic2, p_rs2, CONJ);
    end
  end

  // stage 3: full-precision sum register
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      sum3_re <= '0;
      sum3_im <= '0;
    end else if (iclkena) begin
      sum3_re <= sum3_re_c;
      sum3_im <= sum3_im_c;
    end
  end

  if (pUSE_ROUND != 0) begin : g_round
    localparam int unsigned RND_POS = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [SUM_W:0] RND =
      (SHIFT == 0) ? '0 : ((SUM_W + 1)'(1) << RND_POS);

    logic signed [SUM_W:0] rnd_re_c, rnd_im_c;

    // one extra headroom bit so the half-LSB add can never wrap
    always_comb begin
      rnd_re_c = (SUM_W + 1)'(sum3_re) + RND;
      rnd_im_c = (SUM_W + 1)'(sum3_im) + RND;
    end

    always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
        odat_re <= '0;
        odat_im <= '0;
      end else if (iclkena) begin
        odat_re <= pODAT_W'(rnd_re_c >>> SHIFT);
        odat_im <= pODAT_W'(rnd_im_c >>> SHIFT);
      end
    end
  end else begin : g_trunc
    // truncating output is a pure bit-select of the sum register
    assign odat_re = pODAT_W'(sum3_re >>> SHIFT);
    assign odat_im = pODAT_W'(sum3_im >>> SHIFT);
  end

endmodule

// File: tb/tb_cmplx_mixer.sv
// Directed and streamed checks of cmplx_mixer in four configurations
// (default, conjugate, truncating, separate adder) driven by common stimulus.
module tb_cmplx_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, ena, val;
  logic signed [15:0] re, im;
  logic signed [16:0] c, s;

  logic               d_val, cj_val, tr_val, sp_val;
  logic signed [17:0] d_re, d_im, cj_re, cj_im, tr_re, tr_im, sp_re, sp_im;

  cmplx_mixer u_dut (
    .iclk(clk), .ireset(rst_n), .iclkena(ena), .ival(val),
    .idat_re(re), .idat_im(im), .icos(c), .isin(s),
    .oval(d_val), .odat_re(d_re), .odat_im(d_im));

  cmplx_mixer #(.pCONJ(1)) u_conj (
    .iclk(clk), .ireset(rst_n), .iclkena(ena), .ival(val),
    .idat_re(re), .idat_im(im), .icos(c), .isin(s),
    .oval(cj_val), .odat_re(cj_re), .odat_im(cj_im));

  cmplx_mixer #(.pUSE_ROUND(0)) u_trunc (
    .iclk(clk), .ireset(rst_n), .iclkena(ena), .ival(val),
    .idat_re(re), .idat_im(im), .icos(c), .isin(s),
    .oval(tr_val), .odat_re(tr_re), .odat_im(tr_im));

  cmplx_mixer #(.pUSE_DSP_ADD(0)) u_sep (
    .iclk(clk), .ireset(rst_n), .iclkena(ena), .ival(val),
    .idat_re(re), .idat_im(im), .icos(c), .isin(s),
    .oval(sp_val), .odat_re(sp_re), .odat_im(sp_im));

  int n_tests = 0;
  int n_fail  = 0;

  // truncating instance outputs captured at its latency of 3
  logic   t_val;
  longint t_re, t_im;

  // reference pipeline for the default (round, latency 4) configuration
  logic   mv [4];
  longint mre[4];
  longint mim[4];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint r, input longint i, input longint co, input longint si,
                       input logic v);
    re  = 16'(r);
    im  = 16'(i);
    c   = 17'(co);
    s   = 17'(si);
    val = v;
  endtask

  // single valid pulse; leaves time at the 4-cycle output point
  task automatic pulse(input longint r, input longint i, input longint co, input longint si);
    drive(r, i, co, si, 1'b1);
    step();
    val = 1'b0;
    step();
    step();
    t_val = tr_val;
    t_re  = tr_re;
    t_im  = tr_im;
    step();
  endtask

  // reference: round half-up then arithmetic shift by 15
  function automatic void model(input longint r, input longint i, input longint co,
                                input longint si, output longint o_re, output longint o_im);
    longint pr, pi;
    pr   = r * co - i * si;
    pi   = r * si + i * co;
    o_re = (pr + 64'sd16384) >>> 15;
    o_im = (pi + 64'sd16384) >>> 15;
  endfunction

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    drive(0, 0, 0, 0, 1'b0);
    #12;
    check("rst_oval", d_val, 0);
    check("rst_re",   d_re,  0);
    check("rst_im",   d_im,  0);
    check("rst_tr_oval", tr_val, 0);
    step();
    rst_n = 1'b1;
    step();

    // unity cosine passes the sample through after exactly 4 cycles
    drive(1000, -2000, 32768, 0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) val = 1'b0;
      check("t1_oval", d_val, (k == 4) ? 1 : 0);
      if (k == 4) begin
        check("t1_re", d_re, 1000);
        check("t1_im", d_im, -2000);
      end
    end

    // unity sine: rotate by +90 degrees, or -90 when conjugated
    pulse(1000, -2000, 0, 32768);
    check("t2_oval",    d_val,  1);
    check("t2_re",      d_re,   2000);
    check("t2_im",      d_im,   1000);
    check("t2_conj_re", cj_re, -2000);
    check("t2_conj_im", cj_im, -1000);
    check("t2_sep_re",  sp_re,  2000);
    check("t2_tr_oval", t_val,  1);
    check("t2_tr_re",   t_re,   2000);

    // half-LSB products: round up vs truncate
    pulse(1, 0, 16384, 0);
    check("t3_rnd_p1",  d_re, 1);
    check("t3_trc_p1",  t_re, 0);
    check("t3_tr_oval", t_val, 1);
    check("t3_rnd_im",  d_im, 0);
    pulse(-1, 0, 16384, 0);
    check("t3_rnd_m1",  d_re, 0);
    check("t3_trc_m1",  t_re, -1);
    check("t3_trc_im",  t_im, 0);

    // largest magnitudes still fit in 18 bits
    pulse(-32768, -32768, 32768, 32768);
    check("t4_re",      d_re,   0);
    check("t4_im",      d_im,  -65536);
    check("t4_conj_re", cj_re, -65536);
    check("t4_conj_im", cj_im,  0);
    check("t4_sep_im",  sp_im, -65536);

    // streaming vs reference, with a 3-cycle enable drop mid-stream
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mv[k]  = 1'b0;
      mre[k] = 0;
      mim[k] = 0;
    end
    for (int n = 0; n < 60; n++) begin
      longint r, i, co, si, er, ei;
      r  = longint'($urandom_range(65535)) - 32768;
      i  = longint'($urandom_range(65535)) - 32768;
      co = longint'($urandom_range(65536)) - 32768;
      si = longint'($urandom_range(65536)) - 32768;
      drive(r, i, co, si, (n < 50) ? 1'b1 : 1'b0);
      ena = (n >= 25 && n < 28) ? 1'b0 : 1'b1;
      model(r, i, co, si, er, ei);
      step();
      if (ena) begin
        for (int k = 3; k > 0; k--) begin
          mv[k]  = mv[k-1];
          mre[k] = mre[k-1];
          mim[k] = mim[k-1];
        end
        mv[0]  = val;
        mre[0] = er;
        mim[0] = ei;
      end
      check("st_oval",   d_val,  mv[3]);
      check("st_re",     d_re,   mre[3]);
      check("st_im",     d_im,   mim[3]);
      check("st_sep_re", sp_re,  mre[3]);
      check("st_sep_im", sp_im,  mim[3]);
    end
    ena = 1'b1;

    // async reset with samples in flight
    drive(1000, -2000, 32768, 0, 1'b1);
    repeat (5) step();
    check("t6_pre_oval", d_val, 1);
    check("t6_pre_re",   d_re,  1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_oval",    d_val,  0);
    check("t6_rst_re",      d_re,   0);
    check("t6_rst_im",      d_im,   0);
    check("t6_rst_tr_oval", tr_val, 0);
    val = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t6_post_oval",    d_val,  0);
      check("t6_post_tr_oval", tr_val, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
